// File: rtl/armleo_axi_bram_client.sv
// AXI4 slave that serves one transaction at a time from a single-port
// synchronous RAM. Handles FIXED/INCR/WRAP and narrow bursts, reports
// SLVERR for illegal bursts and DECERR for beats outside the RAM.
module armleo_axi_bram_client #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 1024,
  localparam int DATA_STROBES = DATA_WIDTH / 8,
  localparam int MEM_AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    upstream_axi_awvalid,
  output logic                    upstream_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   upstream_axi_awaddr,
  input  logic [7:0]              upstream_axi_awlen,
  input  logic [2:0]              upstream_axi_awsize,
  input  logic [1:0]              upstream_axi_awburst,
  input  logic                    upstream_axi_awlock,
  input  logic [ID_WIDTH-1:0]     upstream_axi_awid,
  input  logic [2:0]              upstream_axi_awprot,

  input  logic                    upstream_axi_wvalid,
  output logic                    upstream_axi_wready,
  input  logic [DATA_WIDTH-1:0]   upstream_axi_wdata,
  input  logic [DATA_STROBES-1:0] upstream_axi_wstrb,
  input  logic                    upstream_axi_wlast,

  output logic                    upstream_axi_bvalid,
  input  logic                    upstream_axi_bready,
  output logic [1:0]              upstream_axi_bresp,
  output logic [ID_WIDTH-1:0]     upstream_axi_bid,

  input  logic                    upstream_axi_arvalid,
  output logic                    upstream_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   upstream_axi_araddr,
  input  logic [7:0]              upstream_axi_arlen,
  input  logic [2:0]              upstream_axi_arsize,
  input  logic [1:0]              upstream_axi_arburst,
  input  logic                    upstream_axi_arlock,
  input  logic [ID_WIDTH-1:0]     upstream_axi_arid,
  input  logic [2:0]              upstream_axi_arprot,

  output logic                    upstream_axi_rvalid,
  input  logic                    upstream_axi_rready,
  output logic [1:0]              upstream_axi_rresp,
  output logic                    upstream_axi_rlast,
  output logic [DATA_WIDTH-1:0]   upstream_axi_rdata,
  output logic [ID_WIDTH-1:0]     upstream_axi_rid,

  output logic [MEM_AW-1:0]       mem_addr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_STROBES-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int LANE_BITS = $clog2(DATA_STROBES);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH * DATA_STROBES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_R_ISSUE,
    S_R_VALID,
    S_W_DATA,
    S_W_RESP
  } state_t;

  // Lock and prot carry no meaning for a plain RAM.
  logic w_unused;
  assign w_unused = ^{upstream_axi_awlock, upstream_axi_awprot,
                      upstream_axi_arlock, upstream_axi_arprot};

  function automatic logic burst_illegal(input logic [7:0] len,
                                         input logic [2:0] size,
                                         input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'(LANE_BITS)) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [ID_WIDTH-1:0]     r_id;
  logic                    r_err;
  logic [7:0]              r_cnt;
  logic [1:0]              r_bresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_rfresh;
  logic                    r_last_was_write;

  logic                    w_sel_write, w_sel_read;
  logic                    w_in_range, w_beat_ok, w_last_beat;
  logic [1:0]              w_beat_resp, w_wbeat_worst, w_bresp_next;
  logic [ADDR_WIDTH-1:0]   w_step, w_wrap_mask, w_next_addr;
  logic [MEM_AW-1:0]       w_mem_index;
  logic [DATA_WIDTH-1:0]   w_rdata_live;

  // Round-robin between channels only when both request simultaneously.
  assign w_sel_write = upstream_axi_awvalid && (!upstream_axi_arvalid || !r_last_was_write);
  assign w_sel_read  = upstream_axi_arvalid && !w_sel_write;

  assign w_in_range  = {1'b0, r_addr} < ADDR_LIMIT;
  assign w_beat_resp = r_err ? RESP_SLVERR : (w_in_range ? RESP_OKAY : RESP_DECERR);
  assign w_beat_ok   = (w_beat_resp == RESP_OKAY);
  assign w_last_beat = (r_cnt == r_len);
  assign w_mem_index = MEM_AW'(r_addr >> LANE_BITS);

  assign w_step      = ADDR_WIDTH'(1) << r_size;
  assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);

  // RAM data is only present the cycle after mem_read; afterwards use the held copy.
  assign w_rdata_live = r_rfresh ? (w_beat_ok ? mem_rdata : '0) : r_rdata;

  // A mismatched wlast degrades an otherwise good beat to SLVERR.
  assign w_wbeat_worst = ((upstream_axi_wlast != w_last_beat) && (w_beat_resp == RESP_OKAY))
                         ? RESP_SLVERR : w_beat_resp;
  assign w_bresp_next  = (w_wbeat_worst > r_bresp) ? w_wbeat_worst : r_bresp;

  // Address of the following beat for the latched burst type.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    w_next_addr = r_addr;
    case (r_burst)
      BURST_INCR: w_next_addr = r_addr + w_step;
      BURST_WRAP: w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
      default:    w_next_addr = r_addr;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and all handshake / memory outputs.
  always_comb begin
    w_state_next         = r_state;
    upstream_axi_awready = 1'b0;
    upstream_axi_arready = 1'b0;
    upstream_axi_wready  = 1'b0;
    upstream_axi_bvalid  = 1'b0;
    upstream_axi_bresp   = RESP_OKAY;
    upstream_axi_bid     = '0;
    upstream_axi_rvalid  = 1'b0;
    upstream_axi_rresp   = RESP_OKAY;
    upstream_axi_rlast   = 1'b0;
    upstream_axi_rdata   = '0;
    upstream_axi_rid     = '0;
    mem_addr             = '0;
    mem_read             = 1'b0;
    mem_write            = 1'b0;
    mem_wdata            = '0;
    mem_wstrb            = '0;
    case (r_state)
      S_IDLE: begin
        upstream_axi_awready = w_sel_write;
        upstream_axi_arready = w_sel_read;
        if (w_sel_write)     w_state_next = S_W_DATA;
        else if (w_sel_read) w_state_next = S_R_ISSUE;
      end
      S_R_ISSUE: begin
        mem_addr     = w_mem_index;
        mem_read     = w_beat_ok;
        w_state_next = S_R_VALID;
      end
      S_R_VALID: begin
        upstream_axi_rvalid = 1'b1;
        upstream_axi_rdata  = w_rdata_live;
        upstream_axi_rresp  = w_beat_resp;
        upstream_axi_rlast  = w_last_beat;
        upstream_axi_rid    = r_id;
        if (upstream_axi_rready) w_state_next = w_last_beat ? S_IDLE : S_R_ISSUE;
      end
      S_W_DATA: begin
        upstream_axi_wready = 1'b1;
        mem_addr            = w_mem_index;
        mem_wdata           = upstream_axi_wdata;
        mem_wstrb           = upstream_axi_wstrb;
        if (upstream_axi_wvalid) begin
          mem_write = w_beat_ok;
          if (w_last_beat) w_state_next = S_W_RESP;
        end
      end
      S_W_RESP: begin
        upstream_axi_bvalid = 1'b1;
        upstream_axi_bresp  = r_bresp;
        upstream_axi_bid    = r_id;
        if (upstream_axi_bready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Burst context: latch on acceptance, advance address and beat counter per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr           <= '0;
      r_len            <= '0;
      r_size           <= '0;
      r_burst          <= '0;
      r_id             <= '0;
      r_err            <= 1'b0;
      r_cnt            <= '0;
      r_bresp          <= RESP_OKAY;
      r_rdata          <= '0;
      r_rfresh         <= 1'b0;
      r_last_was_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_bresp  <= RESP_OKAY;
          r_rfresh <= 1'b0;
          if (w_sel_write) begin
            r_addr  <= upstream_axi_awaddr;
            r_len   <= upstream_axi_awlen;
            r_size  <= upstream_axi_awsize;
            r_burst <= upstream_axi_awburst;
            r_id    <= upstream_axi_awid;
            r_err   <= burst_illegal(upstream_axi_awlen, upstream_axi_awsize, upstream_axi_awburst);
          end else if (w_sel_read) begin
            r_addr  <= upstream_axi_araddr;
            r_len   <= upstream_axi_arlen;
            r_size  <= upstream_axi_arsize;
            r_burst <= upstream_axi_arburst;
            r_id    <= upstream_axi_arid;
            r_err   <= burst_illegal(upstream_axi_arlen, upstream_axi_arsize, upstream_axi_arburst);
          end
        end
        S_R_ISSUE: r_rfresh <= 1'b1;
        S_R_VALID: begin
          if (r_rfresh) begin
            r_rdata  <= w_rdata_live;
            r_rfresh <= 1'b0;
          end
          if (upstream_axi_rready) begin
            if (w_last_beat) begin
              r_last_was_write <= 1'b0;
            end else begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        S_W_DATA: begin
          if (upstream_axi_wvalid) begin
            r_bresp <= w_bresp_next;
            if (!w_last_beat) begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        S_W_RESP: if (upstream_axi_bready) r_last_was_write <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_armleo_axi_bram_client.sv
// Self-checking bench for armleo_axi_bram_client: directed scenarios plus a
// randomized mix, checked against a byte-level memory model and burst
// address arithmetic computed directly from the AXI rules.
module tb_armleo_axi_bram_client;
  localparam int AW = 32, DW = 32, IW = 4, DEPTH = 1024;
  localparam int NS = DW / 8, MAW = $clog2(DEPTH);
  localparam longint LIMIT = longint'(DEPTH) * NS;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, awprot, arsize, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [DW-1:0] wdata, rdata;
  logic [NS-1:0] wstrb;
  logic          arvalid, arready, arlock, rvalid, rready, rlast;
  logic [MAW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [NS-1:0] mem_wstrb;

  armleo_axi_bram_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .upstream_axi_awvalid(awvalid), .upstream_axi_awready(awready), .upstream_axi_awaddr(awaddr),
    .upstream_axi_awlen(awlen), .upstream_axi_awsize(awsize), .upstream_axi_awburst(awburst),
    .upstream_axi_awlock(awlock), .upstream_axi_awid(awid), .upstream_axi_awprot(awprot),
    .upstream_axi_wvalid(wvalid), .upstream_axi_wready(wready), .upstream_axi_wdata(wdata),
    .upstream_axi_wstrb(wstrb), .upstream_axi_wlast(wlast),
    .upstream_axi_bvalid(bvalid), .upstream_axi_bready(bready), .upstream_axi_bresp(bresp),
    .upstream_axi_bid(bid),
    .upstream_axi_arvalid(arvalid), .upstream_axi_arready(arready), .upstream_axi_araddr(araddr),
    .upstream_axi_arlen(arlen), .upstream_axi_arsize(arsize), .upstream_axi_arburst(arburst),
    .upstream_axi_arlock(arlock), .upstream_axi_arid(arid), .upstream_axi_arprot(arprot),
    .upstream_axi_rvalid(rvalid), .upstream_axi_rready(rready), .upstream_axi_rresp(rresp),
    .upstream_axi_rlast(rlast), .upstream_axi_rdata(rdata), .upstream_axi_rid(rid),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM seen by the DUT.
  bit [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_write)
      for (int b = 0; b < NS; b++)
        if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_read) mem_rdata <= ram[mem_addr];
  end

  // Log of every RAM access the DUT performs.
  int unsigned   wr_log[$], rd_log[$];
  logic [DW-1:0] wd_log[$];
  logic [NS-1:0] ws_log[$];
  always @(negedge clk) begin
    if (mem_write) begin
      wr_log.push_back(int'(mem_addr));
      wd_log.push_back(mem_wdata);
      ws_log.push_back(mem_wstrb);
    end
    if (mem_read) rd_log.push_back(int'(mem_addr));
  end

  // Reference model state.
  bit [DW-1:0] ref_mem [DEPTH];
  int checks = 0, errors = 0;

  logic [31:0] c_addr;
  logic [7:0]  c_len;
  logic [2:0]  c_size;
  logic [1:0]  c_burst;
  logic [3:0]  c_id;
  logic [DW-1:0] wd_in[$];
  logic [NS-1:0] ws_in[$];
  bit            wl_in[$];

  function automatic bit m_burst_ok(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return (size <= 3'd2) && (burst != 2'b11) &&
           (burst != 2'b10 || len == 1 || len == 3 || len == 7 || len == 15);
  endfunction

  // Address of beat i: FIXED stays, INCR steps, WRAP cycles within an aligned window.
  function automatic logic [31:0] m_addr(input logic [31:0] a, input int i, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    longint step, total, off;
    step = longint'(1) << size;
    case (burst)
      2'b01: return 32'(longint'(a) + i * step);
      2'b10: begin
        total = (longint'(len) + 1) * step;
        off   = (longint'(a) % total + i * step) % total;
        return 32'(longint'(a) - longint'(a) % total + off);
      end
      default: return a;
    endcase
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a, input bit burst_ok);
    if (!burst_ok) return 2'b10;
    if (longint'(a) >= LIMIT) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic hs_sig(input int ch);
    case (ch)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      default: return rvalid;
    endcase
  endfunction

  function automatic bit outs_zero();
    return ({awready, arready, wready, bvalid, bresp, bid, rvalid, rresp, rlast, rdata, rid,
             mem_addr, mem_read, mem_write, mem_wdata, mem_wstrb} === '0);
  endfunction

  // Wait (bounded) until the selected ready/valid is seen high at a negedge.
  task automatic wait_hs(input int ch, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (hs_sig(ch) === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL handshake_timeout channel=%0d got=no_handshake want=handshake", ch);
    end
  endtask

  task automatic set_w_random();
    wd_in.delete(); ws_in.delete(); wl_in.delete();
    for (int i = 0; i <= int'(c_len); i++) begin
      wd_in.push_back($urandom);
      ws_in.push_back(NS'($urandom));
      wl_in.push_back(i == int'(c_len));
    end
  endtask

  // Drive the W beats of the accepted burst, update the model, check RAM writes.
  task automatic w_beats(output logic [1:0] exp_resp);
    int unsigned exp_w[$];
    logic [DW-1:0] exp_d[$];
    logic [NS-1:0] exp_s[$];
    logic [31:0] a;
    logic [1:0]  r;
    bit ok, bok;
    int base, w;
    base = wr_log.size();
    exp_resp = 2'b00;
    bok = m_burst_ok(c_len, c_size, c_burst);
    for (int i = 0; i <= int'(c_len); i++) begin
      a = m_addr(c_addr, i, c_len, c_size, c_burst);
      r = m_resp(a, bok);
      if (r > exp_resp) exp_resp = r;
      if (wl_in[i] != (i == int'(c_len)) && exp_resp < 2'b10) exp_resp = 2'b10;
      if (r == 2'b00) begin
        w = int'(a) / NS;
        exp_w.push_back(w); exp_d.push_back(wd_in[i]); exp_s.push_back(ws_in[i]);
        for (int b = 0; b < NS; b++) if (ws_in[i][b]) ref_mem[w][8*b +: 8] = wd_in[i][8*b +: 8];
      end
      wvalid = 1'b1; wdata = wd_in[i]; wstrb = ws_in[i]; wlast = wl_in[i];
      wait_hs(1, ok);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if (wr_log.size() - base !== exp_w.size()) begin
      errors++;
      $display("FAIL write_count got=%0d want=%0d", wr_log.size() - base, exp_w.size());
    end else begin
      for (int j = 0; j < exp_w.size(); j++) begin
        checks++;
        if (wr_log[base+j] !== exp_w[j] || wd_log[base+j] !== exp_d[j] || ws_log[base+j] !== exp_s[j]) begin
          errors++;
          $display("FAIL write_beat%0d got=idx%0d/%h/%b want=idx%0d/%h/%b", j,
                   wr_log[base+j], wd_log[base+j], ws_log[base+j], exp_w[j], exp_d[j], exp_s[j]);
        end
      end
    end
  endtask

  task automatic b_phase(output logic [1:0] got_resp, output logic [3:0] got_id);
    bit ok;
    bready = 1'b1;
    wait_hs(2, ok);
    got_resp = bresp; got_id = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Collect R beats (optionally stalling one), check each beat and the RAM read sequence.
  task automatic r_beats(input int stall_beat, input int stall_cycles);
    int unsigned exp_r[$];
    logic [31:0] a;
    logic [1:0]  r;
    logic [DW-1:0] exp_d, d;
    bit ok, bok;
    int base;
    base = rd_log.size();
    bok = m_burst_ok(c_len, c_size, c_burst);
    for (int i = 0; i <= int'(c_len); i++) begin
      a = m_addr(c_addr, i, c_len, c_size, c_burst);
      r = m_resp(a, bok);
      exp_d = (r == 2'b00) ? ref_mem[int'(a) / NS] : '0;
      if (r == 2'b00) exp_r.push_back(int'(a) / NS);
      rready = 1'b0;
      wait_hs(4, ok);
      d = rdata;
      checks++;
      if ({rdata, rresp, rlast, rid} !== {exp_d, r, (i == int'(c_len)), c_id}) begin
        errors++;
        $display("FAIL read_beat%0d got=%h/%b/%b/%h want=%h/%b/%b/%h", i, rdata, rresp, rlast, rid,
                 exp_d, r, (i == int'(c_len)), c_id);
      end
      if (i == stall_beat) begin
        repeat (stall_cycles) begin
          @(negedge clk);
          checks++;
          if (rvalid !== 1'b1 || rdata !== d) begin
            errors++;
            $display("FAIL read_stall_stable got=%b/%h want=1/%h", rvalid, rdata, d);
          end
        end
      end
      @(posedge clk); #1;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
    checks++;
    if (rd_log.size() - base !== exp_r.size()) begin
      errors++;
      $display("FAIL read_count got=%0d want=%0d", rd_log.size() - base, exp_r.size());
    end else begin
      for (int j = 0; j < exp_r.size(); j++) begin
        checks++;
        if (rd_log[base+j] !== exp_r[j]) begin
          errors++;
          $display("FAIL read_index%0d got=%0d want=%0d", j, rd_log[base+j], exp_r[j]);
        end
      end
    end
  endtask

  task automatic drive_aw();
    awaddr = c_addr; awlen = c_len; awsize = c_size; awburst = c_burst; awid = c_id;
    awvalid = 1'b1;
  endtask

  task automatic drive_ar();
    araddr = c_addr; arlen = c_len; arsize = c_size; arburst = c_burst; arid = c_id;
    arvalid = 1'b1;
  endtask

  task automatic axi_write(output logic [1:0] exp_resp, output logic [1:0] got_resp, output logic [3:0] got_id);
    bit ok;
    drive_aw();
    wait_hs(0, ok);
    @(posedge clk); #1;
    awvalid = 1'b0;
    w_beats(exp_resp);
    b_phase(got_resp, got_id);
  endtask

  task automatic axi_read(input int stall_beat, input int stall_cycles);
    bit ok;
    drive_ar();
    wait_hs(3, ok);
    @(posedge clk); #1;
    arvalid = 1'b0;
    r_beats(stall_beat, stall_cycles);
  endtask

  task automatic set_ctx(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    c_addr = a; c_len = len; c_size = size; c_burst = burst; c_id = id;
  endtask

  task automatic write_and_check(input string name);
    logic [1:0] er, gr;
    logic [3:0] gi;
    axi_write(er, gr, gi);
    checks++;
    if (gr !== er || gi !== c_id) begin
      errors++;
      $display("FAIL %s_bresp got=%b/%h want=%b/%h", name, gr, gi, er, c_id);
    end
  endtask

  task automatic test_reset();
    {awvalid, wvalid, bready, arvalid, rready, wlast, awlock, arlock} = '0;
    {awaddr, araddr, awlen, arlen, awsize, arsize, awburst, arburst, awid, arid} = '0;
    {awprot, arprot, wdata, wstrb} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (!outs_zero()) begin errors++; $display("FAIL reset_outputs got=nonzero want=zero"); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (!outs_zero()) begin errors++; $display("FAIL idle_outputs got=nonzero want=zero"); end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    logic [1:0] er, gr;
    logic [3:0] gi;
    bit ok;
    set_ctx(32'h100, 8'd0, 3'd2, 2'b01, 4'd3);
    drive_aw();
    araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = 4'd9;
    arvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, arready} !== 2'b10) begin
      errors++; $display("FAIL arb_first got=%b want=10", {awready, arready});
    end
    @(posedge clk); #1;
    set_w_random();
    w_beats(er);
    b_phase(gr, gi);
    checks++;
    if (gr !== er || gi !== 4'd3) begin errors++; $display("FAIL arb_w1_bresp got=%b/%h want=%b/3", gr, gi, er); end
    @(negedge clk);
    checks++;
    if ({awready, arready} !== 2'b01) begin
      errors++; $display("FAIL arb_second got=%b want=01", {awready, arready});
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    set_ctx(32'h100, 8'd0, 3'd2, 2'b01, 4'd9);
    r_beats(-1, 0);
    @(negedge clk);
    checks++;
    if ({awready, arready} !== 2'b10) begin
      errors++; $display("FAIL arb_third got=%b want=10", {awready, arready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    set_ctx(32'h100, 8'd0, 3'd2, 2'b01, 4'd3);
    set_w_random();
    w_beats(er);
    b_phase(gr, gi);
    checks++;
    if (gr !== er || gi !== 4'd3) begin errors++; $display("FAIL arb_w2_bresp got=%b/%h want=%b/3", gr, gi, er); end
    ok = 1'b1;
  endtask

  task automatic test_early_w();
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = '1; wlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (wready !== 1'b0 || mem_write !== 1'b0) begin
        errors++; $display("FAIL early_w got=%b/%b want=0/0", wready, mem_write);
      end
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic test_incr_write();
    int base;
    base = wr_log.size();
    set_ctx(32'h10, 8'd3, 3'd2, 2'b01, 4'd5);
    set_w_random();
    for (int i = 0; i < 4; i++) begin wd_in[i] = 32'hA + i; ws_in[i] = 4'hF; end
    write_and_check("incr_write");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_log.size() <= base + i || wr_log[base+i] !== 4 + i) begin
        errors++; $display("FAIL incr_write_index%0d want=%0d", i, 4 + i);
      end
    end
  endtask

  task automatic test_wrap_read();
    int base;
    int unsigned want[4];
    want = '{14, 15, 12, 13};
    base = rd_log.size();
    set_ctx(32'h38, 8'd3, 3'd2, 2'b10, 4'd7);
    axi_read(1, 3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log.size() <= base + i || rd_log[base+i] !== want[i]) begin
        errors++; $display("FAIL wrap_read_index%0d want=%0d", i, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    set_ctx(32'(LIMIT), 8'd1, 3'd2, 2'b01, 4'd2);
    axi_read(-1, 0);
    set_ctx(32'h20, 8'd2, 3'd2, 2'b10, 4'd4);
    set_w_random();
    write_and_check("wrap_len2");
  endtask

  task automatic test_wlast();
    set_ctx(32'h40, 8'd1, 3'd2, 2'b01, 4'd6);
    set_w_random();
    wl_in[0] = 1'b1; wl_in[1] = 1'b0;
    write_and_check("wlast_early");
  endtask

  task automatic test_narrow();
    int base;
    base = wr_log.size();
    set_ctx(32'h3, 8'd1, 3'd0, 2'b01, 4'd8);
    set_w_random();
    ws_in[0] = 4'b1000; ws_in[1] = 4'b0001;
    write_and_check("narrow");
    checks++;
    if (wr_log.size() < base + 2 || wr_log[base] !== 0 || wr_log[base+1] !== 1) begin
      errors++; $display("FAIL narrow_index want=0,1");
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    set_ctx(32'h10, 8'd3, 3'd2, 2'b01, 4'd1);
    drive_ar();
    wait_hs(3, ok);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b0;
    wait_hs(4, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!outs_zero()) begin errors++; $display("FAIL midburst_reset got=nonzero want=zero"); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(-1, 0);
  endtask

  task automatic test_long_burst();
    set_ctx(32'h0, 8'd255, 3'd2, 2'b01, 4'hA);
    set_w_random();
    write_and_check("len255");
    axi_read(200, 2);
  endtask

  task automatic test_random();
    logic [7:0] wrap_lens[4];
    wrap_lens = '{8'd1, 8'd3, 8'd7, 8'd15};
    for (int t = 0; t < 40; t++) begin
      c_size  = 3'($urandom_range(0, 2));
      c_burst = 2'($urandom_range(0, 2));
      c_len   = (c_burst == 2'b10) ? wrap_lens[$urandom_range(0, 3)] : 8'($urandom_range(0, 15));
      c_addr  = $urandom_range(0, 4400);
      c_id    = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        c_addr = $urandom_range(0, 255);
        case ($urandom_range(0, 2))
          0: c_size = 3'd3;
          1: c_burst = 2'b11;
          default: begin c_burst = 2'b10; c_len = 8'd2; end
        endcase
      end
      if ($urandom_range(0, 1) == 0) begin
        set_w_random();
        write_and_check("random_write");
      end else begin
        axi_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_early_w();
    test_incr_write();
    test_wrap_read();
    test_errors();
    test_wlast();
    test_narrow();
    test_reset_mid_burst();
    test_long_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
